// File: rtl/serial_sub_fsm.sv
// serial_sub_fsm: bit-serial unsigned subtractor, diff = a - b mod 2^WIDTH, LSB first.
// Latency: start accepted at edge E0, WIDTH SHIFT cycles, done pulses in cycle WIDTH+1.
// Backpressure: none; start is ignored while busy, min start-to-start spacing WIDTH+2.
// Optional zero-result flag port enabled by defining SERIAL_SUB_ZERO_FLAG_EN.
module serial_sub_fsm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_ZERO_FLAG_EN
  output logic             bout,
  output logic             zero
`else
  output logic             bout
`endif
);

  // Counter is one bit wider than needed so WIDTH itself is representable.
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic             br;
  logic [CNT_W-1:0] cnt;

  // Full-subtractor cell built from two half-subtractors plus the borrow flop.
  logic             hs1_d;
  logic             hs1_b;
  logic             hs2_d;
  logic             hs2_b;
  logic             br_nxt;
  logic [WIDTH-1:0] sr_nxt;

  // Combinational cell on the current LSBs; result bit enters sr at the MSB end.
  always_comb begin
    hs1_d  = sa[0] ^ sb[0];
    hs1_b  = ~sa[0] & sb[0];
    hs2_d  = hs1_d ^ br;
    hs2_b  = ~hs1_d & br;
    br_nxt = hs1_b | hs2_b;
    // Shift-then-overwrite form stays legal when WIDTH is 1.
    sr_nxt            = sr >> 1;
    sr_nxt[WIDTH-1]   = hs2_d;
  end

  // Control FSM and datapath registers; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
      zero  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            br    <= 1'b0;
            cnt   <= '0;
            sr    <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          br  <= br_nxt;
          sr  <= sr_nxt;
          cnt <= cnt + 1'b1;
          // Final bit processed this cycle: publish the result on DONE entry.
          if (cnt == LAST_CNT) begin
            diff  <= sr_nxt;
            bout  <= br_nxt;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
            zero  <= (sr_nxt == '0);
`endif
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_fsm.sv
// Directed bench for serial_sub_fsm at WIDTH=8 and WIDTH=1.
// Checks reset state, cycle timing of busy/done, arithmetic, ignored starts and mid-op reset.
// Zero-flag checks are compiled in only when SERIAL_SUB_ZERO_FLAG_EN is defined.
module tb_serial_sub_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;
  logic       start1 = 1'b0;
  logic       a1 = 1'b0;
  logic       b1 = 1'b0;
  logic       busy1;
  logic       done1;
  logic       diff1;
  logic       bout1;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
  logic       zero;
  logic       zero1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_sub_fsm #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff),
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    .bout(bout), .zero(zero)
`else
    .bout(bout)
`endif
  );

  serial_sub_fsm #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1),
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    .bout(bout1), .zero(zero1)
`else
    .bout(bout1)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one WIDTH=8 operation and check timing and results.
  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic [7:0] ed, input logic eb);
    int cyc;
    a = ta; b = tb_v; start = 1'b1;
    tick;
    start = 1'b0;
    a = ~ta; b = ~tb_v;
    cyc = 1;
    check({tag, "_busy_c1"}, 32'(busy), 32'd1);
    while (done !== 1'b1 && cyc < 30) begin
      tick;
      cyc++;
    end
    check({tag, "_done_cycle"}, 32'(cyc), 32'd9);
    check({tag, "_busy_done"}, 32'(busy), 32'd1);
    check({tag, "_diff"}, 32'(diff), 32'(ed));
    check({tag, "_bout"}, 32'(bout), 32'(eb));
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    check({tag, "_zero"}, 32'(zero), 32'(ed == 8'h00));
`endif
    tick;
    check({tag, "_done_off"}, 32'(done), 32'd0);
    check({tag, "_busy_off"}, 32'(busy), 32'd0);
    check({tag, "_diff_hold"}, 32'(diff), 32'(ed));
  endtask

  // Issue one WIDTH=1 operation; done expected in cycle 2.
  task automatic run_op1(input string tag, input logic ta, input logic tb_v,
                         input logic ed, input logic eb);
    int cyc;
    a1 = ta; b1 = tb_v; start1 = 1'b1;
    tick;
    start1 = 1'b0;
    cyc = 1;
    while (done1 !== 1'b1 && cyc < 10) begin
      tick;
      cyc++;
    end
    check({tag, "_done_cycle"}, 32'(cyc), 32'd2);
    check({tag, "_diff"}, 32'(diff1), 32'(ed));
    check({tag, "_bout"}, 32'(bout1), 32'(eb));
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    check({tag, "_zero"}, 32'(zero1), 32'(ed == 1'b0));
`endif
    tick;
    check({tag, "_busy_off"}, 32'(busy1), 32'd0);
  endtask

  initial begin
    int pulses;
    tick;
    tick;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    check("rst_busy1", 32'(busy1), 32'd0);
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    check("rst_zero", 32'(zero), 32'd0);
`endif
    rst = 1'b0;
    tick;
    check("idle_no_start", 32'(busy), 32'd0);

    // Hand-computed vectors.
    run_op("v5a_23", 8'h5A, 8'h23, 8'h37, 1'b0);
    run_op("v10_20", 8'h10, 8'h20, 8'hF0, 1'b1);
    run_op("v00_ff", 8'h00, 8'hFF, 8'h01, 1'b1);
    run_op("v7f_7f", 8'h7F, 8'h7F, 8'h00, 1'b0);
    run_op("v02_01", 8'h02, 8'h01, 8'h01, 1'b0);
    run_op("vff_00", 8'hFF, 8'h00, 8'hFF, 1'b0);
    run_op("v80_01", 8'h80, 8'h01, 8'h7F, 1'b0);
    run_op("v00_01", 8'h00, 8'h01, 8'hFF, 1'b1);
    run_op("v01_80", 8'h01, 8'h80, 8'h81, 1'b1);
    run_op("vc3_3c", 8'hC3, 8'h3C, 8'h87, 1'b0);

    // Start re-pulsed during SHIFT is ignored; result stays from first op.
    a = 8'h5A; b = 8'h23; start = 1'b1;
    tick;
    start = 1'b0;
    pulses = 0;
    tick;
    tick;
    check("hold_diff_in_shift", 32'(diff), 32'h87);
    a = 8'hFF; b = 8'h00; start = 1'b1;
    tick;
    tick;
    start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (done === 1'b1) begin
        pulses++;
        check("repulse_diff", 32'(diff), 32'h37);
        check("repulse_bout", 32'(bout), 32'd0);
      end
      tick;
    end
    check("repulse_one_done", 32'(pulses), 32'd1);
    check("repulse_idle", 32'(busy), 32'd0);

    // Reset in the middle of SHIFT discards the operation.
    a = 8'h10; b = 8'h20; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_diff", 32'(diff), 32'd0);
    check("midrst_bout", 32'(bout), 32'd0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) pulses++;
      tick;
    end
    check("midrst_no_done", 32'(pulses), 32'd0);
    run_op("after_rst", 8'h5A, 8'h23, 8'h37, 1'b0);

    // Reset and start on the same edge: reset wins.
    rst = 1'b1; start = 1'b1; a = 8'h02; b = 8'h01;
    tick;
    rst = 1'b0; start = 1'b0;
    check("rst_start_busy", 32'(busy), 32'd0);
    tick;
    check("rst_start_busy2", 32'(busy), 32'd0);
    check("rst_start_diff", 32'(diff), 32'd0);

    // WIDTH=1 instance.
    run_op1("w1_00", 1'b0, 1'b0, 1'b0, 1'b0);
    run_op1("w1_10", 1'b1, 1'b0, 1'b1, 1'b0);
    run_op1("w1_01", 1'b0, 1'b1, 1'b1, 1'b1);
    run_op1("w1_11", 1'b1, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
